// File: rtl/pulse_id_pkg.sv
// Shared types and constants for the pulse-ID persistence controller.
// Holds the FSM encoding and the restore arithmetic.
package pulse_id_pkg;

  localparam int PULSE_ID_W = 64;

  localparam logic [PULSE_ID_W-1:0] BLANK_ID = '1;

  typedef enum logic [2:0] {
    BOOT_WAIT,
    READ_REQ,
    READ_WAIT,
    RESTORE,
    IDLE,
    WRITE_REQ,
    WRITE_WAIT
  } state_e;

  // Erased MRAM reads back all-ones: start from zero instead of skipping.
  function automatic logic [PULSE_ID_W-1:0] restore_calc(
    input logic [PULSE_ID_W-1:0] rdata,
    input logic [PULSE_ID_W-1:0] skip
  );
    if (rdata == BLANK_ID) return '0;
    return rdata + skip;
  endfunction

endpackage

// File: rtl/op_timeout.sv
// Saturating cycle counter for MRAM wait supervision.
// expired stays high once the limit is reached, until cleared.
module op_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic expired
);

  localparam int unsigned W =
    (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/pulse_id_persist_ctrl.sv
// Restores the pulse-ID from MRAM at boot and saves it on each tick.
// Ticks arriving mid-write collapse into one pending save.
module pulse_id_persist_ctrl
  import pulse_id_pkg::*;
#(
  parameter logic [PULSE_ID_W-1:0] RESTORE_SKIP = 64'd100,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  save_enable,
  input  logic [PULSE_ID_W-1:0] pulse_id_in,
  output logic [PULSE_ID_W-1:0] restored_id,
  output logic                  restore_valid,
  output logic                  id_valid,
  output logic                  blank,
  output logic                  busy,
  output logic [15:0]           overrun_cnt,
  output logic                  mram_fault,
  output logic                  mram_start,
  output logic                  mram_write,
  output logic [PULSE_ID_W-1:0] mram_wdata,
  input  logic                  mram_ready,
  input  logic [PULSE_ID_W-1:0] mram_rdata
);

  state_e state, state_nx;

  logic                  pending;
  logic [PULSE_ID_W-1:0] shadow;
  logic [PULSE_ID_W-1:0] wdata_q;

  logic tick_ok;
  logic waiting;
  logic to_clear;
  logic to_expired;
  logic set_pend;
  logic clr_pend;
  logic latch_sh;
  logic load_wd;
  logic inc_ovr;
  logic rd_done;

  assign tick_ok = tick & save_enable & id_valid;

  assign waiting = (state == BOOT_WAIT) ||
                   (state == READ_WAIT) ||
                   (state == WRITE_WAIT);

  assign to_clear = (state_nx != state) &&
                    ((state_nx == BOOT_WAIT) ||
                     (state_nx == READ_WAIT) ||
                     (state_nx == WRITE_WAIT));

  op_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (to_clear),
    .expired(to_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= BOOT_WAIT;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    mram_start = 1'b0;
    set_pend   = 1'b0;
    clr_pend   = 1'b0;
    latch_sh   = 1'b0;
    load_wd    = 1'b0;
    inc_ovr    = 1'b0;
    rd_done    = 1'b0;
    unique case (state)
      BOOT_WAIT: begin
        if (mram_ready) state_nx = READ_REQ;
      end
      READ_REQ: begin
        if (mram_ready) begin
          mram_start = 1'b1;
          state_nx   = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (mram_ready) begin
          rd_done  = 1'b1;
          state_nx = RESTORE;
        end
      end
      RESTORE: begin
        state_nx = IDLE;
      end
      IDLE: begin
        if (tick_ok) begin
          latch_sh = 1'b1;
          load_wd  = 1'b1;
          state_nx = WRITE_REQ;
        end
      end
      WRITE_REQ: begin
        if (mram_ready) begin
          mram_start = 1'b1;
          state_nx   = WRITE_WAIT;
        end
        if (tick_ok) begin
          latch_sh = 1'b1;
          inc_ovr  = pending;
          set_pend = ~pending;
        end
      end
      WRITE_WAIT: begin
        if (tick_ok) begin
          latch_sh = 1'b1;
          inc_ovr  = pending;
          set_pend = ~pending;
        end
        // A tick landing on the exit edge counts as the pending save.
        if (mram_ready) begin
          clr_pend = 1'b1;
          if (pending || tick_ok) begin
            load_wd  = 1'b1;
            state_nx = WRITE_REQ;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = BOOT_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= 1'b0;
      shadow      <= '0;
      wdata_q     <= '0;
      restored_id <= '0;
      id_valid    <= 1'b0;
      blank       <= 1'b0;
      overrun_cnt <= '0;
      mram_fault  <= 1'b0;
    end else begin
      if (clr_pend)      pending <= 1'b0;
      else if (set_pend) pending <= 1'b1;
      if (latch_sh) shadow <= pulse_id_in;
      if (load_wd)  wdata_q <= latch_sh ? pulse_id_in : shadow;
      if (rd_done) begin
        restored_id <= restore_calc(mram_rdata, RESTORE_SKIP);
        if (mram_rdata == BLANK_ID) blank <= 1'b1;
      end
      if (state == RESTORE) id_valid <= 1'b1;
      if (inc_ovr && (overrun_cnt != 16'hFFFF)) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end
      if (waiting && to_expired) mram_fault <= 1'b1;
    end
  end

  assign restore_valid = (state == RESTORE);
  assign busy          = (state != IDLE);
  assign mram_write    = (state == WRITE_REQ) ||
                         (state == WRITE_WAIT);
  assign mram_wdata    = wdata_q;

endmodule

// File: tb/tb_pulse_id_persist_ctrl.sv
// Scoreboard bench: directed stimulus queues expected MRAM starts and
// restores; a monitor checks them as the DUT presents them.
module tb_pulse_id_persist_ctrl;

  localparam int unsigned TO = 20;

  logic        clk;
  logic        reset_n;
  logic        tick;
  logic        save_enable;
  logic [63:0] pulse_id_in;
  logic [63:0] restored_id;
  logic        restore_valid;
  logic        id_valid;
  logic        blank;
  logic        busy;
  logic [15:0] overrun_cnt;
  logic        mram_fault;
  logic        mram_start;
  logic        mram_write;
  logic [63:0] mram_wdata;
  logic        mram_ready;
  logic [63:0] mram_rdata;

  typedef struct {
    logic        wr;
    logic [63:0] wd;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] rst_q[$];

  int errs = 0;
  int checks = 0;
  int rv_cnt = 0;

  logic eng_en = 1'b0;
  int   lat = 3;

  pulse_id_persist_ctrl #(
    .RESTORE_SKIP  (64'd100),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .save_enable  (save_enable),
    .pulse_id_in  (pulse_id_in),
    .restored_id  (restored_id),
    .restore_valid(restore_valid),
    .id_valid     (id_valid),
    .blank        (blank),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt),
    .mram_fault   (mram_fault),
    .mram_start   (mram_start),
    .mram_write   (mram_write),
    .mram_wdata   (mram_wdata),
    .mram_ready   (mram_ready),
    .mram_rdata   (mram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // MRAM engine model: ready while idle, low for lat cycles after start.
  initial begin
    logic s;
    int   rem;
    rem = 0;
    mram_ready = 1'b0;
    forever begin
      @(negedge clk);
      s = mram_start;
      @(posedge clk);
      #1;
      if (!eng_en) begin
        rem = 0;
        mram_ready = 1'b0;
      end else if (s) begin
        rem = lat;
        mram_ready = (lat == 0);
      end else if (rem > 0) begin
        rem--;
        mram_ready = (rem == 0);
      end else begin
        mram_ready = 1'b1;
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a start or restore.
  initial begin
    exp_t        e;
    logic [63:0] r;
    logic [63:0] act_wd;
    logic        act_ok;
    act_ok = 1'b0;
    act_wd = '0;
    forever begin
      @(negedge clk);
      if (mram_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_start: got start wr=%0b wd=0x%0h expected none",
                   mram_write, mram_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("start_write", {63'd0, mram_write}, {63'd0, e.wr});
          if (e.wr) chk("start_wdata", mram_wdata, e.wd);
        end
        act_wd = mram_wdata;
        act_ok = 1'b1;
      end else if (mram_write && act_ok) begin
        chk("wdata_stable", mram_wdata, act_wd);
      end else if (!mram_write) begin
        act_ok = 1'b0;
      end
      if (restore_valid) begin
        rv_cnt++;
        if (rst_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_restore: got id=0x%0h expected none",
                   restored_id);
        end else begin
          r = rst_q.pop_front();
          chk("restored_id_pulse", restored_id, r);
        end
      end
    end
  end

  function automatic logic cond(input int sel);
    case (sel)
      0:       return (busy == 1'b0);
      1:       return (id_valid == 1'b1);
      default: return (mram_fault == 1'b1);
    endcase
  endfunction

  task automatic wait_for(input string nm, input int sel, input int max);
    int n;
    n = 0;
    while (!cond(sel) && n < max) begin
      cyc();
      n++;
    end
    checks++;
    if (!cond(sel)) begin
      errs++;
      $display("FAIL %s: not reached in %0d cycles, expected reached",
               nm, max);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_restored_id"}, restored_id, 64'd0);
    chk({tag, "_restore_valid"}, {63'd0, restore_valid}, 64'd0);
    chk({tag, "_id_valid"}, {63'd0, id_valid}, 64'd0);
    chk({tag, "_blank"}, {63'd0, blank}, 64'd0);
    chk({tag, "_overrun"}, {48'd0, overrun_cnt}, 64'd0);
    chk({tag, "_fault"}, {63'd0, mram_fault}, 64'd0);
    chk({tag, "_start"}, {63'd0, mram_start}, 64'd0);
    chk({tag, "_write"}, {63'd0, mram_write}, 64'd0);
    chk({tag, "_wdata"}, mram_wdata, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
  endtask

  task automatic do_tick(input logic [63:0] v);
    tick = 1'b1;
    pulse_id_in = v;
    cyc();
    tick = 1'b0;
  endtask

  task automatic push_wr(input logic [63:0] v);
    exp_t e;
    e.wr = 1'b1;
    e.wd = v;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [63:0] rid);
    exp_t e;
    e.wr = 1'b0;
    e.wd = '0;
    exp_q.push_back(e);
    rst_q.push_back(rid);
  endtask

  initial begin
    reset_n = 1'b0;
    tick = 1'b0;
    save_enable = 1'b1;
    pulse_id_in = '0;
    mram_rdata = 64'h1234;
    lat = 3;
    repeat (3) cyc();
    chk_reset("por");
    reset_n = 1'b1;

    // Tick before restore must be ignored.
    cyc();
    do_tick(64'h55);
    repeat (7) cyc();
    push_rd(64'h1298);
    eng_en = 1'b1;
    wait_for("boot_done", 1, 50);
    chk("boot_id", restored_id, 64'h1298);
    chk("boot_blank", {63'd0, blank}, 64'd0);
    chk("boot_busy", {63'd0, busy}, 64'd0);

    // save_enable low: no write.
    save_enable = 1'b0;
    do_tick(64'h66);
    save_enable = 1'b1;
    repeat (5) cyc();
    chk("disabled_busy", {63'd0, busy}, 64'd0);

    // Single save; input changes right after to prove the latch.
    push_wr(64'hABCD);
    do_tick(64'hABCD);
    pulse_id_in = 64'h1111;
    wait_for("save_done", 0, 40);

    // Three ticks in one write: pending then one overrun.
    lat = 10;
    push_wr(64'd5);
    push_wr(64'd7);
    do_tick(64'd5);
    cyc();
    do_tick(64'd6);
    cyc();
    do_tick(64'd7);
    wait_for("overrun_done", 0, 80);
    chk("overrun_cnt", {48'd0, overrun_cnt}, 64'd1);

    // Timeout during a write; the write still completes.
    lat = TO + 5;
    push_wr(64'h99);
    do_tick(64'h99);
    wait_for("fault_set", 2, 60);
    chk("fault_flag", {63'd0, mram_fault}, 64'd1);
    wait_for("timeout_done", 0, 60);
    chk("fault_sticky", {63'd0, mram_fault}, 64'd1);

    // Reset in the middle of WRITE_WAIT.
    lat = 50;
    push_wr(64'h77);
    do_tick(64'h77);
    repeat (5) cyc();
    chk("mid_write", {63'd0, mram_write}, 64'd1);
    reset_n = 1'b0;
    eng_en = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (8) cyc();
    chk("reboot_wait_busy", {63'd0, busy}, 64'd1);
    mram_rdata = '1;
    lat = 2;
    push_rd(64'd0);
    eng_en = 1'b1;
    wait_for("blank_boot", 1, 50);
    chk("blank_id", restored_id, 64'd0);
    chk("blank_flag", {63'd0, blank}, 64'd1);

    // Wraparound on restore.
    reset_n = 1'b0;
    eng_en = 1'b0;
    cyc();
    chk("wrap_rst_blank", {63'd0, blank}, 64'd0);
    reset_n = 1'b1;
    mram_rdata = 64'hFFFF_FFFF_FFFF_FFF0;
    cyc();
    push_rd(64'h54);
    eng_en = 1'b1;
    wait_for("wrap_boot", 1, 50);
    chk("wrap_id", restored_id, 64'h54);
    chk("wrap_blank", {63'd0, blank}, 64'd0);

    repeat (3) cyc();
    chk("starts_left", 64'(exp_q.size()), 64'd0);
    chk("restores_left", 64'(rst_q.size()), 64'd0);
    chk("restore_pulses", 64'(rv_cnt), 64'd3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pulse_id_persist_ctrl.md
PULSE_ID_PERSIST_CTRL -- requirements
Module: pulse_id_persist_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; every other port SHALL be synchronous to the clock.
REQ-002 Parameter RESTORE_SKIP, default 100: 64-bit unsigned increment added to the restored pulse-ID.
REQ-003 Parameter TIMEOUT_CYCLES, default 1048576: clocks allowed per MRAM wait before a fault is flagged.
REQ-004 Port clk  in  1  system clock.
REQ-005 Port reset_n  in  1  asynchronous active-low reset.
REQ-006 Port tick  in  1  single-cycle 100 Hz save strobe.
REQ-007 Port save_enable  in  1  level; 0 ignores ticks.
REQ-008 Port pulse_id_in  in  64  live pulse-ID counter value.
REQ-009 Port restored_id  out  64  restored start value for the pulse-ID counter.
REQ-010 Port restore_valid  out  1  one-cycle load strobe for restored_id.
REQ-011 Port id_valid  out  1  sticky; high once the restore is done.
REQ-012 Port blank  out  1  sticky; MRAM read returned all-ones.
REQ-013 Port busy  out  1  high when the FSM is not in IDLE.
REQ-014 Port overrun_cnt  out  16  saturating count of dropped saves.
REQ-015 Port mram_fault  out  1  sticky timeout flag.
REQ-016 Ports to the MRAM engine: mram_start out 1; mram_write out 1; mram_wdata out 64; mram_ready in 1; mram_rdata in 64.

Function
REQ-017 FSM states SHALL be BOOT_WAIT, READ_REQ, READ_WAIT, RESTORE, IDLE, WRITE_REQ, WRITE_WAIT.
REQ-018 BOOT_WAIT SHALL go to READ_REQ on the first cycle mram_ready=1, which marks MRAM init complete.
REQ-019 In READ_REQ and WRITE_REQ, mram_start SHALL be asserted combinationally for exactly one cycle, in the cycle mram_ready=1; the FSM SHALL advance to the matching *_WAIT state on that edge.
REQ-020 mram_write SHALL be 1 in WRITE_REQ and WRITE_WAIT and 0 otherwise; mram_wdata SHALL hold the shadow register stable from WRITE_REQ until WRITE_WAIT exits.
REQ-021 A *_WAIT state SHALL exit on the first cycle mram_ready=1; mram_rdata is valid in that cycle.
REQ-022 On READ_WAIT exit, the block SHALL capture restored_id = mram_rdata + RESTORE_SKIP, modulo 2^64 (wrap, no saturation), and enter RESTORE.
REQ-023 If mram_rdata = 0xFFFF_FFFF_FFFF_FFFF, the block SHALL set restored_id = 0 and set blank.
REQ-024 RESTORE SHALL pulse restore_valid for one cycle, set id_valid, and go to IDLE.
REQ-025 Ticks SHALL be ignored, and not counted, before id_valid=1 or while save_enable=0.
REQ-026 An accepted tick in IDLE SHALL latch pulse_id_in into the shadow register and enter WRITE_REQ on the next edge.
REQ-027 A tick accepted in WRITE_REQ or WRITE_WAIT with pending=0 SHALL set pending and re-latch the shadow register.
REQ-028 A tick accepted in WRITE_REQ or WRITE_WAIT with pending=1 SHALL re-latch the shadow register and increment overrun_cnt, saturating at 0xFFFF.
REQ-029 On WRITE_WAIT exit, if pending=1 the FSM SHALL clear pending and go directly to WRITE_REQ; otherwise it SHALL go to IDLE.
REQ-030 If a tick coincides with WRITE_WAIT exit, it SHALL be treated as pending, so the FSM goes to WRITE_REQ.
REQ-031 The timeout counter SHALL clear on entry to BOOT_WAIT, READ_WAIT and WRITE_WAIT.
REQ-032 If any such wait lasts TIMEOUT_CYCLES cycles, mram_fault SHALL set; the FSM SHALL keep waiting and never abort the engine.

Reset
REQ-033 On reset_n=0, all state SHALL clear asynchronously: FSM=BOOT_WAIT, pending=0, shadow=0.
REQ-034 Output reset values SHALL be: restored_id=0, restore_valid=0, id_valid=0, blank=0, overrun_cnt=0, mram_fault=0, mram_start=0, mram_write=0, mram_wdata=0, busy=1.
REQ-035 After reset release mid-operation, the block SHALL restart from BOOT_WAIT and wait for mram_ready=1 before issuing any start.

Structure
REQ-036 Package pulse_id_pkg SHALL hold the state enum and the constants PULSE_ID_W=64 and BLANK_ID (all-ones).
REQ-037 The timeout counter SHALL be a sub-module named op_timeout, with ports clk, reset_n, clear, expired and parameter TIMEOUT_CYCLES.

Verification
REQ-038 Boot: mram_ready rises at cycle 10 with rdata=0x1234 -> exactly one mram_start with mram_write=0; restored_id=0x1298 with one restore_valid pulse; id_valid=1.
REQ-039 Blank: rdata=all-ones -> restored_id=0, blank=1; wrap: rdata=0xFFFF_FFFF_FFFF_FFF0 -> restored_id=0x54.
REQ-040 Save: tick with pulse_id_in=0xABCD in IDLE -> mram_start with mram_write=1 and mram_wdata=0xABCD held stable until ready returns.
REQ-041 Overrun: three ticks during one write (values 5, 6, 7) -> second write carries 7; overrun_cnt=1.
REQ-042 Timeout: mram_ready held 0 for TIMEOUT_CYCLES -> mram_fault=1; a later ready=1 still completes the operation.
REQ-043 Reset mid-WRITE_WAIT -> all outputs at reset values; no mram_start until mram_ready=1.
